// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants and state type for the priority interrupt controller
package pic_pkg;

    localparam int N_IRQ = 8;
    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } pic_state_e;

endpackage

// File: rtl/pic_prio_enc8.sv
// rtl/pic_prio_enc8.sv - 8-to-3 priority encoder, bit 7 highest
module pic_prio_enc8
    import pic_pkg::*;
(
    input  logic [N_IRQ-1:0] req_i,
    output logic [VEC_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req_i[i]) begin
                idx_o   = VEC_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_interrupt_controller.sv
// rtl/priority_interrupt_controller.sv - synchronised, masked, prioritised interrupt request front-end
module priority_interrupt_controller
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic             timeout
);

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic       TIMER_ON   = (ACK_TIMEOUT != 0);

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0]                  prev_q;
    logic [N_IRQ-1:0]                  sync_last;
    logic [N_IRQ-1:0]                  irq_edge;

    pic_state_e       state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d, pend_clr;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic             int_req_q, int_req_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       timer_q, timer_d;

    logic [N_IRQ-1:0] eligible;
    logic [VEC_W-1:0] enc_idx;
    logic             enc_valid;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign irq_edge  = sync_last & ~prev_q;
    assign eligible  = pending_q & ~mask;

    pic_prio_enc8 u_enc (
        .req_i   (eligible),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Synchroniser chain plus one extra flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= sync_last;
        end
    end

    // Handshake FSM next state; a new edge beats an ack clear on the same bit
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_vec_d    = int_vec_q;
        timer_d      = timer_q;
        timeout_d    = 1'b0;
        in_service_d = in_service_q;
        pend_clr     = '0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    int_vec_d = enc_idx;
                    int_req_d = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    pend_clr[int_vec_q]     = 1'b1;
                    in_service_d            = '0;
                    in_service_d[int_vec_q] = 1'b1;
                    int_req_d               = 1'b0;
                    state_d                 = SERVICE;
                end else if (TIMER_ON && (timer_q == TIMER_LAST)) begin
                    int_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~pend_clr) | irq_edge;
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_vec_q    <= '0;
            timeout_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_vec_q    <= int_vec_d;
            timeout_q    <= timeout_d;
            timer_q      <= timer_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_vec    = int_vec_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_priority_interrupt_controller.sv
// tb/tb_priority_interrupt_controller.sv - self-checking bench for priority_interrupt_controller
module tb_priority_interrupt_controller;

    localparam int SYNC   = 2;
    localparam int ACK_TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = '0;
    logic [7:0] mask = '0;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       int_req;
    logic [2:0] int_vec;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    priority_interrupt_controller #(
        .SYNC_STAGES (SYNC),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask       (mask),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: request index bookkeeping with -1 meaning "none"
    int         m_pres = -1;
    int         m_serv = -1;
    int         m_last = 0;
    int         m_wait = 0;
    logic [7:0] m_pend = '0;
    bit         m_to = 1'b0;
    logic [7:0] hist [0:SYNC];

    task automatic model_reset();
        m_pres = -1; m_serv = -1; m_last = 0; m_wait = 0; m_pend = '0; m_to = 1'b0;
        for (int j = 0; j <= SYNC; j++) hist[j] = '0;
    endtask

    task automatic model_step();
        logic [7:0] rise, clr, elig;
        rise = hist[SYNC-1] & ~hist[SYNC];
        clr  = '0;
        m_to = 1'b0;
        if (m_pres >= 0) begin
            if (int_ack) begin
                clr[m_pres] = 1'b1;
                m_serv = m_pres;
                m_pres = -1;
            end else if (ACK_TO != 0 && m_wait == ACK_TO - 1) begin
                m_pres = -1;
                m_to = 1'b1;
            end else if (m_wait < 255) begin
                m_wait++;
            end
        end else if (m_serv >= 0) begin
            if (eoi) m_serv = -1;
        end else begin
            elig = m_pend & ~mask;
            if (elig != 0) begin
                m_pres = $clog2(int'(elig) + 1) - 1;
                m_last = m_pres;
                m_wait = 0;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = irq_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model int_req", 32'(int_req), 32'(m_pres >= 0));
                check("model int_vec", 32'(int_vec), 32'(m_last));
                check("model pending", 32'(pending), 32'(m_pend));
                check("model in_service", 32'(in_service), (m_serv >= 0) ? (32'd1 << m_serv) : 32'd0);
                check("model timeout", 32'(timeout), 32'(m_to));
            end
        end
    end

    typedef struct {
        logic [7:0] irq;
        logic [7:0] msk;
        logic       ack;
        logic       eoi;
        int         n;
        logic       req;
        logic [2:0] vec;
        logic [7:0] pend;
        logic [7:0] isv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] irq, input logic [7:0] msk, input logic ack,
                       input logic e, input int n, input logic req, input logic [2:0] vec,
                       input logic [7:0] pend, input logic [7:0] isv);
        vec_t v;
        v.irq = irq; v.msk = msk; v.ack = ack; v.eoi = e; v.n = n;
        v.req = req; v.vec = vec; v.pend = pend; v.isv = isv;
        tbl.push_back(v);
    endtask

    int hi;

    initial begin
        // single request
        add(8'h08, 8'h00, 0, 0, 3, 0, 3'd0, 8'h08, 8'h00);
        add(8'h08, 8'h00, 0, 0, 1, 1, 3'd3, 8'h08, 8'h00);
        add(8'h08, 8'h00, 1, 0, 1, 0, 3'd3, 8'h00, 8'h08);
        add(8'h08, 8'h00, 0, 1, 1, 0, 3'd3, 8'h00, 8'h00);
        add(8'h00, 8'h00, 0, 0, 3, 0, 3'd3, 8'h00, 8'h00);
        // priority, no preemption
        add(8'h05, 8'h00, 0, 0, 3, 0, 3'd3, 8'h05, 8'h00);
        add(8'h05, 8'h00, 0, 0, 1, 1, 3'd2, 8'h05, 8'h00);
        add(8'h45, 8'h00, 0, 0, 4, 1, 3'd2, 8'h45, 8'h00);
        add(8'h45, 8'h00, 1, 0, 1, 0, 3'd2, 8'h41, 8'h04);
        add(8'h45, 8'h00, 0, 1, 1, 0, 3'd2, 8'h41, 8'h00);
        add(8'h45, 8'h00, 0, 0, 1, 1, 3'd6, 8'h41, 8'h00);
        add(8'h45, 8'h00, 1, 0, 1, 0, 3'd6, 8'h01, 8'h40);
        add(8'h45, 8'h00, 0, 1, 1, 0, 3'd6, 8'h01, 8'h00);
        add(8'h45, 8'h00, 0, 0, 1, 1, 3'd0, 8'h01, 8'h00);
        add(8'h45, 8'h00, 1, 0, 1, 0, 3'd0, 8'h00, 8'h01);
        add(8'h45, 8'h00, 0, 1, 1, 0, 3'd0, 8'h00, 8'h00);
        add(8'h00, 8'h00, 0, 0, 3, 0, 3'd0, 8'h00, 8'h00);
        // mask
        add(8'h82, 8'h80, 0, 0, 3, 0, 3'd0, 8'h82, 8'h00);
        add(8'h82, 8'h80, 0, 0, 1, 1, 3'd1, 8'h82, 8'h00);
        add(8'h82, 8'h80, 1, 0, 1, 0, 3'd1, 8'h80, 8'h02);
        add(8'h82, 8'h80, 0, 1, 1, 0, 3'd1, 8'h80, 8'h00);
        add(8'h82, 8'h80, 0, 0, 2, 0, 3'd1, 8'h80, 8'h00);
        add(8'h82, 8'h00, 0, 0, 1, 1, 3'd7, 8'h80, 8'h00);
        add(8'h82, 8'h00, 1, 0, 1, 0, 3'd7, 8'h00, 8'h80);
        add(8'h82, 8'h00, 0, 1, 1, 0, 3'd7, 8'h00, 8'h00);
        add(8'h00, 8'h00, 0, 0, 3, 0, 3'd7, 8'h00, 8'h00);
        // stray ack / eoi while idle
        add(8'h00, 8'h00, 1, 1, 2, 0, 3'd7, 8'h00, 8'h00);

        tick(3);
        check("reset int_req", 32'(int_req), 32'd0);
        check("reset int_vec", 32'(int_vec), 32'd0);
        check("reset pending", 32'(pending), 32'd0);
        check("reset in_service", 32'(in_service), 32'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        foreach (tbl[r]) begin
            irq_in = tbl[r].irq; mask = tbl[r].msk; int_ack = tbl[r].ack; eoi = tbl[r].eoi;
            tick(tbl[r].n);
            check($sformatf("row%0d int_req", r), 32'(int_req), 32'(tbl[r].req));
            check($sformatf("row%0d int_vec", r), 32'(int_vec), 32'(tbl[r].vec));
            check($sformatf("row%0d pending", r), 32'(pending), 32'(tbl[r].pend));
            check($sformatf("row%0d in_service", r), 32'(in_service), 32'(tbl[r].isv));
        end
        int_ack = 1'b0; eoi = 1'b0;

        // timeout after 16 cycles in REQ, then immediate re-request
        irq_in = 8'h20;
        tick(4);
        check("to enter int_req", 32'(int_req), 32'd1);
        check("to enter int_vec", 32'(int_vec), 32'd5);
        hi = 1;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (int_req) hi++;
            else break;
        end
        check("to req cycles", 32'(hi), 32'd16);
        check("to pulse", 32'(timeout), 32'd1);
        check("to pending kept", 32'(pending), 32'h20);
        tick(1);
        check("to pulse width", 32'(timeout), 32'd0);
        check("to re-request", 32'(int_req), 32'd1);
        check("to re-request vec", 32'(int_vec), 32'd5);
        int_ack = 1'b1; tick(1);
        int_ack = 1'b0; eoi = 1'b1; tick(1);
        eoi = 1'b0; irq_in = 8'h00; tick(3);

        // new edge on bit 4 lands on the same cycle as its ack
        irq_in = 8'h10;
        tick(4);
        check("col int_req", 32'(int_req), 32'd1);
        check("col int_vec", 32'(int_vec), 32'd4);
        irq_in = 8'h00; tick(1);
        irq_in = 8'h10; tick(2);
        int_ack = 1'b1; tick(1);
        int_ack = 1'b0;
        check("col pending", 32'(pending), 32'h10);
        check("col in_service", 32'(in_service), 32'h10);
        eoi = 1'b1; tick(1);
        eoi = 1'b0;
        check("col eoi", 32'(in_service), 32'd0);
        tick(1);
        check("col re-present", 32'(int_req), 32'd1);
        check("col re-present vec", 32'(int_vec), 32'd4);
        int_ack = 1'b1; tick(1);
        int_ack = 1'b0; eoi = 1'b1; tick(1);
        eoi = 1'b0; irq_in = 8'h00; tick(3);

        // asynchronous reset in the middle of a request
        irq_in = 8'h10;
        tick(4);
        check("rst pre int_req", 32'(int_req), 32'd1);
        check("rst pre pending", 32'(pending), 32'h10);
        rst = 1'b1; irq_in = 8'h00;
        #1;
        check("rst async int_req", 32'(int_req), 32'd0);
        check("rst async pending", 32'(pending), 32'd0);
        check("rst async in_service", 32'(in_service), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(4);
        check("rst no side effect", 32'(int_req), 32'd0);

        // random traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 699) == 0) rst = 1'b1;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 11) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(0, 19) == 0) mask = 8'($urandom) & 8'($urandom);
            int_ack = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            eoi = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
